// File: rtl/reg_file_param.sv
// Parametrised register file: two combinational read ports, one synchronous write port,
// optional write-to-read bypass, optional hardwired-zero r0 and a one-per-cycle clear sweep.
module reg_file_param #(
  parameter int unsigned DW      = 16,
  parameter int unsigned AW      = 3,
  parameter bit          BYPASS  = 1'b1,
  parameter bit          ZERO_R0 = 1'b0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] W_Addr,
  input  logic [DW-1:0] W,
  input  logic [AW-1:0] R_Addr,
  input  logic [AW-1:0] S_Addr,
  output logic [DW-1:0] R,
  output logic [DW-1:0] S,
  input  logic          clr_req,
  output logic          clr_busy,
  output logic          clr_done,
  output logic          wr_drop
);

  localparam int unsigned Depth = 2 ** AW;

  typedef enum logic [1:0] {StIdle, StClear, StDone} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          drop_q, drop_d;
  logic [DW-1:0] mem_q [Depth];

  logic wr_zero;
  logic wr_accept;

  // A write is taken outside the sweep unless it targets a hardwired-zero r0.
  always_comb begin
    wr_zero   = ZERO_R0 && (W_Addr == '0);
    wr_accept = we && (state_q != StClear) && !wr_zero;
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    drop_d  = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        if (clr_req) begin
          state_d = StClear;
          ptr_d   = '0;
          busy_d  = 1'b1;
        end else begin
          state_d = StIdle;
        end
      end
      StClear: begin
        ptr_d  = ptr_q + AW'(1);
        drop_d = we;
        if (&ptr_q) begin
          state_d = StDone;
          done_d  = 1'b1;
        end else begin
          busy_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      drop_q  <= drop_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else if (state_q == StClear) begin
      mem_q[ptr_q] <= '0;
    end else if (wr_accept) begin
      mem_q[W_Addr] <= W;
    end
  end

  always_comb begin
    R = mem_q[R_Addr];
    if (ZERO_R0 && (R_Addr == '0)) R = '0;
    if (BYPASS && wr_accept && (W_Addr == R_Addr)) R = W;
  end

  always_comb begin
    S = mem_q[S_Addr];
    if (ZERO_R0 && (S_Addr == '0)) S = '0;
    if (BYPASS && wr_accept && (W_Addr == S_Addr)) S = W;
  end

  assign clr_busy = busy_q;
  assign clr_done = done_q;
  assign wr_drop  = drop_q;

endmodule
